// File: rtl/uart_core_if.sv
// Host-side register bus of uart_core: transmit strobe/data, receive strobe/data/status.
interface uart_core_if;
  logic [7:0] tx_data;
  logic       tx_we;
  logic       tx_busy;
  logic       rx_re;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;

  modport master (output tx_data, tx_we, rx_re,
                  input  tx_busy, rx_data, rx_valid, rx_overrun);
  modport slave  (input  tx_data, tx_we, rx_re,
                  output tx_busy, rx_data, rx_valid, rx_overrun);
endinterface

// File: rtl/uart_core.sv
// 8N1 UART with independent TX/RX FSMs. RX storage is a single holding register,
// or an RX_FIFO_DEPTH-entry FIFO when UART_RX_FIFO_EN is defined.
module uart_core #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  uart_core_if.slave bus,
  output logic       txd,
  input  logic       rxd
);
  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- transmitter ----------------
  state_t      tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_busy_q <= 1'b0;
      txd       <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: if (bus.tx_we) begin
          tx_state  <= START;
          tx_shift  <= bus.tx_data;
          tx_busy_q <= 1'b1;
          txd       <= 1'b0;
          tx_cnt    <= '0;
        end
        START: if (tx_cnt == BIT_END) begin
          tx_cnt   <= '0;
          tx_bit   <= '0;
          tx_state <= DATA;
          txd      <= tx_shift[0];
        end else tx_cnt <= tx_cnt + 16'd1;
        DATA: if (tx_cnt == BIT_END) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) begin
            tx_state <= STOP;
            txd      <= 1'b1;
          end else begin
            // shift[0] is the bit on the line; shift[1] goes out next
            tx_bit   <= tx_bit + 3'd1;
            txd      <= tx_shift[1];
            tx_shift <= {1'b0, tx_shift[7:1]};
          end
        end else tx_cnt <= tx_cnt + 16'd1;
        STOP: if (tx_cnt == BIT_END) begin
          tx_cnt    <= '0;
          tx_state  <= IDLE;
          tx_busy_q <= 1'b0;
        end else tx_cnt <= tx_cnt + 16'd1;
      endcase
    end
  end

  assign bus.tx_busy = tx_busy_q;

  // ---------------- receiver ----------------
  logic        rx_s1, rx_s2, rx_prev;
  state_t      rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_push  <= 1'b0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_push <= 1'b0;
      case (rx_state)
        IDLE: if (rx_prev && !rx_s2) begin
          rx_state <= START;
          rx_cnt   <= '0;
        end
        START: if (rx_cnt == HALF_END) begin
          // from here on every BIT_END lands mid-bit
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? IDLE : DATA;
        end else rx_cnt <= rx_cnt + 16'd1;
        DATA: if (rx_cnt == BIT_END) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state <= STOP;
          else                rx_bit   <= rx_bit + 3'd1;
        end else rx_cnt <= rx_cnt + 16'd1;
        STOP: if (rx_cnt == BIT_END) begin
          rx_cnt   <= '0;
          rx_state <= IDLE;
          rx_push  <= rx_s2;
        end else rx_cnt <= rx_cnt + 16'd1;
      endcase
    end
  end

  // ---------------- receive storage ----------------
  logic overrun_q;
  assign bus.rx_overrun = overrun_q;

`ifdef UART_RX_FIFO_EN
  localparam int AW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST     = AW'(RX_FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RX_FIFO_DEPTH);

  logic [7:0]    mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, full, wr;

  assign pop  = bus.rx_re && (count != '0);
  assign full = (count == FULL_CNT);
  assign wr   = rx_push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < RX_FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= rx_shift;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (rx_push && full && !pop) overrun_q <= 1'b1;
    end
  end

  assign bus.rx_data  = mem[rd_ptr];
  assign bus.rx_valid = (count != '0);
`else
  logic [7:0] hold_q;
  logic       valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (bus.rx_re && valid_q) begin
      // a consume in the same cycle makes room for the incoming byte
      if (rx_push) hold_q  <= rx_shift;
      else         valid_q <= 1'b0;
    end else if (rx_push) begin
      if (!valid_q) begin
        hold_q  <= rx_shift;
        valid_q <= 1'b1;
      end else overrun_q <= 1'b1;
    end
  end

  assign bus.rx_data  = hold_q;
  assign bus.rx_valid = valid_q;
`endif
endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: stimulus pushes expected bytes, monitors decode txd
// and drain rx_data independently and compare.
module tb_uart_core;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
`ifdef UART_RX_FIFO_EN
  localparam int RX_CAP = DEPTH;
`else
  localparam int RX_CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic txd;

  uart_core_if bus();

  uart_core #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc = 0, rst_cnt = 0, tx_frames = 0;
  int tx_last = -100000;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [7:0] rx_held[$];
  logic rd_en     = 1'b0;
  logic model_ovr = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_cnt <= rst_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got 0x%0h want nothing", name, act);
  endtask

  // A strobe is accepted only if the previous accepted frame has fully ended.
  task automatic tx_model(input logic [7:0] b);
    if (cyc + 1 - tx_last > FRAME) begin
      tx_exp.push_back(b);
      tx_last = cyc + 1;
    end
  endtask

  task automatic tx_strobe(input logic [7:0] b);
    bus.tx_data = b;
    bus.tx_we   = 1'b1;
    tx_model(b);
    @(negedge clk);
    bus.tx_we = 1'b0;
  endtask

  function automatic logic tx_line(input logic [7:0] b, input int i);
    int k;
    k = i / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic rx_model(input logic [7:0] b);
    if (rd_en)                       rx_exp.push_back(b);
    else if (rx_held.size() < RX_CAP) rx_held.push_back(b);
    else                             model_ovr = 1'b1;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    if (stop) rx_model(b);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // TX monitor: decode every frame at mid-bit; frames cut by reset are dropped.
  initial begin
    logic [7:0] got;
    logic st, sp;
    int r0;
    got = '0;
    forever begin
      @(negedge txd);
      r0 = rst_cnt;
      repeat (CPB/2) @(posedge clk);
      #1 st = txd;
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(posedge clk);
        #1 got[k] = txd;
      end
      repeat (CPB) @(posedge clk);
      #1 sp = txd;
      if (rst_cnt == r0) begin
        tx_frames++;
        chk("tx_framing", {30'd0, st, sp}, 32'd1);
        if (tx_exp.size() == 0) fail_evt("tx_unexpected", got);
        else chk("tx_byte", got, tx_exp.pop_front());
      end
    end
  end

  // RX monitor: consume each presented byte and compare against the scoreboard.
  initial begin
    bus.rx_re = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rx_re) begin
        bus.rx_re = 1'b0;
`ifndef UART_RX_FIFO_EN
        chk("rx_valid_clr", bus.rx_valid, 1'b0);
`endif
      end else if (rd_en && bus.rx_valid && !rst) begin
        if (rx_exp.size() == 0) fail_evt("rx_unexpected", bus.rx_data);
        else chk("rx_byte", bus.rx_data, rx_exp.pop_front());
        bus.rx_re = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_len, wave_err, lows;
    bus.tx_data = '0;
    bus.tx_we   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", bus.tx_busy, 1'b0);
    chk("rst_valid", bus.rx_valid, 1'b0);
    chk("rst_data", bus.rx_data, 8'h00);
    chk("rst_ovr", bus.rx_overrun, 1'b0);
    rd_en = 1'b1;

    // 0x55 frame, exact waveform and busy length; 0xFF strobe mid-frame must be ignored
    @(negedge clk);
    tx_strobe(8'h55);
    chk("tx_busy_rise", bus.tx_busy, 1'b1);
    busy_len = -1;
    wave_err = 0;
    for (int i = 0; i < FRAME + 40; i++) begin
      if (!bus.tx_busy) begin
        busy_len = i;
        break;
      end
      if (txd !== tx_line(8'h55, i)) wave_err++;
      if (i == 50) begin
        bus.tx_data = 8'hFF;
        bus.tx_we   = 1'b1;
        tx_model(8'hFF);
      end
      if (i == 51) bus.tx_we = 1'b0;
      @(negedge clk);
    end
    chk("tx_busy_len", busy_len, FRAME);
    chk("tx_wave", wave_err, 0);
    // strobe on the very first idle cycle is accepted
    tx_strobe(8'hC3);
    chk("tx_b2b_busy", bus.tx_busy, 1'b1);
    repeat (FRAME + 20) @(negedge clk);
    chk("tx_frames", tx_frames, 2);
    chk("tx_drained", tx_exp.size(), 0);

    // RX: good frame, glitch, framing error, recovery
    rx_frame(8'hA3, 1'b1);
    repeat (20) @(negedge clk);
    chk("rx_a3_drained", rx_exp.size(), 0);
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_push", bus.rx_valid, 1'b0);
    rx_frame(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    chk("ferr_no_push", bus.rx_valid, 1'b0);
    chk("ferr_no_ovr", bus.rx_overrun, 1'b0);
    rx_frame(8'h96, 1'b1);
    repeat (20) @(negedge clk);
    chk("rx_recover", rx_exp.size(), 0);

    // random concurrent TX and RX traffic
    fork
      begin
        for (int n = 0; n < 6; n++) begin
          repeat ($urandom_range(60, 260)) @(negedge clk);
          tx_strobe(8'($urandom));
        end
      end
      begin
        for (int n = 0; n < 6; n++) begin
          repeat ($urandom_range(2, 30)) @(negedge clk);
          rx_frame(8'($urandom), 1'b1);
        end
      end
    join
    repeat (FRAME + 40) @(negedge clk);
    chk("rand_tx_drained", tx_exp.size(), 0);
    chk("rand_rx_drained", rx_exp.size(), 0);

    // overrun: reader stalled
    rd_en = 1'b0;
`ifdef UART_RX_FIFO_EN
    for (int n = 1; n <= 5; n++) rx_frame(8'(n), 1'b1);
`else
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
`endif
    repeat (20) @(negedge clk);
    chk("ovr_valid", bus.rx_valid, 1'b1);
    chk("ovr_head", bus.rx_data, rx_held[0]);
    chk("ovr_flag", bus.rx_overrun, model_ovr);
    rx_exp = rx_held;
    rx_held.delete();
    rd_en = 1'b1;
    repeat (40) @(negedge clk);
    chk("ovr_drained", rx_exp.size(), 0);
    chk("ovr_sticky", bus.rx_overrun, model_ovr);

    // reset in the middle of a TX frame and an RX frame
    @(negedge clk);
    tx_strobe(8'h5A);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (CPB) @(negedge clk);
    rxd = 1'b0;
    repeat (CPB/2) @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    tx_exp.delete();
    tx_last   = -100000;
    model_ovr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_txd", txd, 1'b1);
    chk("mid_rst_busy", bus.tx_busy, 1'b0);
    chk("mid_rst_valid", bus.rx_valid, 1'b0);
    chk("mid_rst_ovr", bus.rx_overrun, model_ovr);
    chk("mid_rst_data", bus.rx_data, 8'h00);
    lows = 0;
    for (int i = 0; i < FRAME + 40; i++) begin
      if (txd !== 1'b1) lows++;
      @(negedge clk);
    end
    chk("post_rst_txd_idle", lows, 0);
    chk("post_rst_no_rx", bus.rx_valid, 1'b0);

    tx_strobe(8'h81);
    repeat (FRAME + 20) @(negedge clk);
    chk("post_rst_tx", tx_exp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per serial bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have parameter RX_FIFO_DEPTH, default 4, giving RX FIFO entries (power of two); used only when UART_RX_FIFO_EN is defined.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port tx_data, input, 8, the byte to transmit, sampled when tx_we=1.
REQ-006 SHALL have port tx_we, input, 1, a one-cycle transmit request strobe.
REQ-007 SHALL have port tx_busy, output, 1, meaning the transmitter is occupied.
REQ-008 SHALL have port rx_re, input, 1, a one-cycle strobe that consumes the current received byte.
REQ-009 SHALL have port rx_data, output, 8, the oldest unconsumed received byte.
REQ-010 SHALL have port rx_valid, output, 1, meaning rx_data holds an unconsumed byte.
REQ-011 SHALL have port rx_overrun, output, 1, a sticky flag set when a received byte is dropped.
REQ-012 SHALL have port txd, output, 1, the serial line out, idle high.
REQ-013 SHALL have port rxd, input, 1, the asynchronous serial line in.

Function
REQ-014 SHALL implement the TX FSM with states IDLE, START, DATA, STOP and a bit counter of 0..7.
REQ-015 SHALL, on tx_we=1 in IDLE, latch tx_data, enter START on the next edge and raise tx_busy on that same edge.
REQ-016 SHALL ignore tx_we=1 while tx_busy=1, leaving the byte in flight unaltered.
REQ-017 SHALL drive txd low for one bit period in START, then 8 data bits LSB first in DATA, then high for one bit period in STOP, where one bit period is CLKS_PER_BIT cycles.
REQ-018 SHALL return to IDLE and drop tx_busy on the edge that ends STOP, so a tx_we on the next cycle is accepted.
REQ-019 SHALL pass rxd through a 2-flop synchronizer before any use.
REQ-020 SHALL implement the RX FSM with states IDLE, START, DATA, STOP.
REQ-021 SHALL enter START from IDLE on a synchronized falling edge.
REQ-022 SHALL recheck the line at CLKS_PER_BIT/2 in START: if low, enter DATA; if high, treat it as a glitch and return to IDLE.
REQ-023 SHALL sample each of the 8 data bits at its mid-bit point, spaced CLKS_PER_BIT apart, LSB first.
REQ-024 SHALL sample the stop bit at mid-bit: if high, push the byte to storage; if low, treat it as a framing error, discard the byte and return to IDLE without pushing.
REQ-025 SHALL, in the base build, use a single holding register for storage.
REQ-026 SHALL, on a push with storage empty, load the byte and set rx_valid=1 on the next edge.
REQ-027 SHALL, on rx_re=1 with rx_valid=1, clear rx_valid on the next edge.
REQ-028 SHALL ignore rx_re=1 while rx_valid=0, with no state change.
REQ-029 SHALL, on a push and rx_re in the same cycle with storage full, load the new byte, keep rx_valid=1 and leave rx_overrun unchanged.
REQ-030 SHALL, on a push with storage full and rx_re=0, drop the new byte, keep the old byte and set rx_overrun=1.
REQ-031 SHALL keep rx_data stable while rx_valid=1 until the consuming rx_re.
REQ-032 SHALL run the RX and TX paths fully independently, with no interaction on simultaneous activity.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, put both FSMs in IDLE and set txd=1, tx_busy=0, rx_valid=0, rx_data=0x00, rx_overrun=0, with all counters and FIFO pointers at 0.
REQ-034 SHALL abort any frame in progress on reset mid-frame: txd goes high on that edge, and a partial RX byte is discarded and never pushed.
REQ-035 SHALL clear rx_overrun only by reset.

Configuration
REQ-036 SHALL, when UART_RX_FIFO_EN is defined, replace the holding register with an RX_FIFO_DEPTH-entry FIFO.
REQ-037 SHALL, in the FIFO build, drive rx_data from the head entry and set rx_valid = not empty.
REQ-038 SHALL, in the FIFO build, perform both operations on a simultaneous push and pop, including when full.
REQ-039 SHALL, in the FIFO build, drop a push when full with no pop and set rx_overrun, with pointers wrapping modulo depth.
REQ-040 SHALL, without UART_RX_FIFO_EN, behave exactly per REQ-025..REQ-031.

Verification (CLKS_PER_BIT=16)
REQ-041 SHALL check: tx_we with 0x55 in IDLE -> tx_busy=1 next cycle; txd reads 0,1,0,1,0,1,0,1,0,1 with each bit 16 cycles; tx_busy=0 exactly 160 cycles after it rose.
REQ-042 SHALL check: second tx_we with 0xFF while the 0x55 frame is busy -> frame unchanged and no 0xFF frame afterwards.
REQ-043 SHALL check: serial 0xA3 driven on rxd with a valid stop bit -> rx_valid=1 with rx_data=0xA3; rx_re pulse -> rx_valid=0 next cycle.
REQ-044 SHALL check: a 4-cycle low glitch on rxd -> no push; a 0x3C frame with stop bit low -> no push and rx_overrun stays 0.
REQ-045 SHALL check, in the base build: 0x11 then 0x22 received without rx_re -> rx_data=0x11 and rx_overrun=1; in the FIFO build, 5 bytes 0x01..0x05 -> reads return 0x01..0x04 and rx_overrun=1.
REQ-046 SHALL check: rst asserted mid TX frame and mid RX frame -> txd=1, tx_busy=0, rx_valid=0 next cycle, and no byte appears.
